// File: rtl/control_unit_if.sv
// Bundle between the control_unit sequencer and its instruction memory / datapath.
// The master side is the sequencer; the slave side is the memory/datapath (or a bench).
interface control_unit_if #(
    parameter int PC_WIDTH      = 8,
    parameter int REG_SEL_WIDTH = 4
);
    logic                     Start;
    logic [15:0]              Instr_Data;
    logic [PC_WIDTH-1:0]      Pc_Out;
    logic [15:0]              Ir_Out;
    logic [REG_SEL_WIDTH-1:0] Reg1_Sel;
    logic [REG_SEL_WIDTH-1:0] Reg2_Sel;
    logic [REG_SEL_WIDTH-1:0] Wr_Sel;
    logic                     Reg_Write;
    logic                     Wb_Sel;
    logic                     Alu_Add;
    logic                     Alu_Sub;
    logic                     Alu_Mul;
    logic                     Alu_Pass;
    logic                     Mem_Read;
    logic                     Mem_Write;
    logic                     Busy;
    logic                     Halted;

    modport master (
        input  Start, Instr_Data,
        output Pc_Out, Ir_Out, Reg1_Sel, Reg2_Sel, Wr_Sel, Reg_Write, Wb_Sel,
               Alu_Add, Alu_Sub, Alu_Mul, Alu_Pass, Mem_Read, Mem_Write, Busy, Halted
    );

    modport slave (
        output Start, Instr_Data,
        input  Pc_Out, Ir_Out, Reg1_Sel, Reg2_Sel, Wr_Sel, Reg_Write, Wb_Sel,
               Alu_Add, Alu_Sub, Alu_Mul, Alu_Pass, Mem_Read, Mem_Write, Busy, Halted
    );
endinterface

// File: rtl/control_unit.sv
// Multi-cycle, non-pipelined instruction sequencer: fetch, decode and drive the
// one-hot ALU strobes, register-file selects/write enable and data-memory strobes.
module control_unit #(
    parameter int PC_WIDTH      = 8,
    parameter int REG_SEL_WIDTH = 4
) (
    input  logic           Clk,
    input  logic           Rst,
    control_unit_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITEBACK,
        S_HALTED
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'h0;
    localparam logic [3:0] OP_SUB   = 4'h1;
    localparam logic [3:0] OP_MUL   = 4'h2;
    localparam logic [3:0] OP_LOAD  = 4'h3;
    localparam logic [3:0] OP_STORE = 4'h4;
    localparam logic [3:0] OP_HALT  = 4'hF;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;

    logic [3:0] opcode;
    logic       is_add, is_sub, is_mul, is_load, is_store, is_halt;
    logic       is_alu, is_mem;

    // Decode always works on the latched instruction so outputs stay Moore.
    always_comb begin
        opcode   = ir_q[15:12];
        is_add   = (opcode == OP_ADD);
        is_sub   = (opcode == OP_SUB);
        is_mul   = (opcode == OP_MUL);
        is_load  = (opcode == OP_LOAD);
        is_store = (opcode == OP_STORE);
        is_halt  = (opcode == OP_HALT);
        is_alu   = is_add | is_sub | is_mul;
        is_mem   = is_load | is_store;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                ir_d    = bus.Instr_Data;
                pc_d    = pc_q + PC_WIDTH'(1);
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_alu || is_mem) begin
                    state_d = S_EXECUTE;
                end else if (is_halt) begin
                    state_d = S_HALTED;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_EXECUTE: begin
                state_d = is_alu ? S_WRITEBACK : S_MEMORY;
            end
            S_MEMORY: begin
                state_d = is_load ? S_WRITEBACK : S_FETCH;
            end
            S_WRITEBACK: begin
                state_d = S_FETCH;
            end
            S_HALTED: begin
                state_d = S_HALTED;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.Pc_Out   = pc_q;
    assign bus.Ir_Out   = ir_q;
    assign bus.Wr_Sel   = REG_SEL_WIDTH'(ir_q[11:8]);
    assign bus.Reg1_Sel = REG_SEL_WIDTH'(ir_q[7:4]);
    assign bus.Reg2_Sel = REG_SEL_WIDTH'(ir_q[3:0]);

    // The opcode strobe and memory strobes stay up into WRITEBACK so the
    // write-back mux sees a stable Alu_Out / read-data source.
    always_comb begin
        bus.Reg_Write = 1'b0;
        bus.Wb_Sel    = 1'b0;
        bus.Alu_Add   = 1'b0;
        bus.Alu_Sub   = 1'b0;
        bus.Alu_Mul   = 1'b0;
        bus.Alu_Pass  = 1'b0;
        bus.Mem_Read  = 1'b0;
        bus.Mem_Write = 1'b0;
        bus.Busy      = (state_q != S_IDLE) && (state_q != S_HALTED);
        bus.Halted    = (state_q == S_HALTED);
        case (state_q)
            S_EXECUTE: begin
                bus.Alu_Add  = is_add;
                bus.Alu_Sub  = is_sub;
                bus.Alu_Mul  = is_mul;
                bus.Alu_Pass = is_mem;
            end
            S_MEMORY: begin
                bus.Alu_Pass  = 1'b1;
                bus.Mem_Read  = is_load;
                bus.Mem_Write = is_store;
            end
            S_WRITEBACK: begin
                bus.Reg_Write = 1'b1;
                bus.Alu_Add   = is_add;
                bus.Alu_Sub   = is_sub;
                bus.Alu_Mul   = is_mul;
                bus.Alu_Pass  = is_load;
                bus.Mem_Read  = is_load;
                bus.Wb_Sel    = is_load;
            end
            default: begin
            end
        endcase
    end

endmodule
